// File: rtl/cbb_stream_packer.sv
// Valid/ready width up-converter: packs P_RATIO narrow beats into one wide word.
// A last marker closes the word early; keep flags which lanes hold beats.
module cbb_stream_packer #(
  parameter int P_IN_WIDTH = 16,
  parameter int P_RATIO    = 4,
  localparam int P_OUT_WIDTH = P_IN_WIDTH * P_RATIO
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   slv_i_valid,
  input  logic [P_IN_WIDTH-1:0]  slv_i_data,
  input  logic                   slv_i_last,
  output logic                   slv_o_ready,
  output logic                   mst_o_valid,
  output logic [P_OUT_WIDTH-1:0] mst_o_data,
  output logic [P_RATIO-1:0]     mst_o_keep,
  output logic                   mst_o_last,
  input  logic                   mst_i_ready
);

  localparam int CNT_W = $clog2(P_RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(P_RATIO - 1);

  logic [CNT_W-1:0]       cnt;
  logic [P_OUT_WIDTH-1:0] acc_data;
  logic [P_RATIO-1:0]     acc_keep;
  logic [P_OUT_WIDTH-1:0] word_data;
  logic [P_RATIO-1:0]     word_keep;
  logic                   accept;
  logic                   close;
  logic                   drain;

  // Ready only looks at the output register and downstream ready.
  assign slv_o_ready = ~mst_o_valid | mst_i_ready;
  assign accept      = slv_i_valid & slv_o_ready;
  assign close       = accept & ((cnt == LAST_LANE) | slv_i_last);
  assign drain       = mst_o_valid & mst_i_ready;

  // Accumulator merged with the incoming beat in lane cnt.
  always_comb begin
    word_data = acc_data;
    word_keep = acc_keep;
    for (int k = 0; k < P_RATIO; k++) begin
      if (cnt == CNT_W'(k)) begin
        word_data[k*P_IN_WIDTH +: P_IN_WIDTH] = slv_i_data;
        word_keep[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt         <= '0;
      acc_data    <= '0;
      acc_keep    <= '0;
      mst_o_valid <= 1'b0;
      mst_o_data  <= '0;
      mst_o_keep  <= '0;
      mst_o_last  <= 1'b0;
    end else if (close) begin
      // Completed word goes straight to the output; covers drain-and-refill too.
      mst_o_valid <= 1'b1;
      mst_o_data  <= word_data;
      mst_o_keep  <= word_keep;
      mst_o_last  <= slv_i_last;
      acc_data    <= '0;
      acc_keep    <= '0;
      cnt         <= '0;
    end else begin
      if (accept) begin
        acc_data <= word_data;
        acc_keep <= word_keep;
        cnt      <= cnt + CNT_W'(1);
      end
      if (drain) begin
        mst_o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cbb_stream_packer.sv
// Bench for cbb_stream_packer: directed vector table, streaming sequence and
// randomized traffic checked against a queue-based packing model.
module tb_cbb_stream_packer;

  localparam int IW = 16;
  localparam int R  = 4;
  localparam int OW = IW * R;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [IW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic          m_valid;
  logic [OW-1:0] m_data;
  logic [R-1:0]  m_keep;
  logic          m_last;
  logic          m_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cbb_stream_packer #(.P_IN_WIDTH(IW), .P_RATIO(R)) dut (
    .i_clk(clk), .i_rst(rst),
    .slv_i_valid(s_valid), .slv_i_data(s_data), .slv_i_last(s_last),
    .slv_o_ready(s_ready),
    .mst_o_valid(m_valid), .mst_o_data(m_data), .mst_o_keep(m_keep),
    .mst_o_last(m_last), .mst_i_ready(m_ready)
  );

  typedef struct {
    logic          rst;
    logic          v;
    logic [IW-1:0] d;
    logic          l;
    logic          mr;
    logic          sr;
    logic          ov;
    logic [OW-1:0] od;
    logic [R-1:0]  ok;
    logic          ol;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic [IW-1:0] d,
                     input logic l, input logic mr, input logic sr,
                     input logic ov, input logic [OW-1:0] od,
                     input logic [R-1:0] ok, input logic ol);
    vec_t e;
    e.rst = r; e.v = v; e.d = d; e.l = l; e.mr = mr;
    e.sr = sr; e.ov = ov; e.od = od; e.ok = ok; e.ol = ol;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle: sample ready before the edge, outputs settle after it.
  task automatic apply(input logic r, input logic v, input logic [IW-1:0] d,
                       input logic l, input logic mr, output logic sr);
    rst = r; s_valid = v; s_data = d; s_last = l; m_ready = mr;
    #2;
    sr = s_ready;
    @(posedge clk);
    #1;
  endtask

  // Reference model state.
  logic [IW-1:0] part[$];
  logic          e_valid;
  logic [OW-1:0] e_data;
  logic [R-1:0]  e_keep;
  logic          e_last;

  initial begin
    logic sr;
    logic exp_sr;
    logic acc;
    int   refills;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //  rst v  data      l  mr | sr ov data                    keep     last
    add(1, 1, 16'h9999, 1, 1,   1, 0, 64'h0,                   4'b0000, 0);
    add(0, 1, 16'h1111, 0, 1,   1, 0, 64'h0,                   4'b0000, 0);
    add(0, 1, 16'h2222, 0, 1,   1, 0, 64'h0,                   4'b0000, 0);
    add(0, 1, 16'h3333, 0, 1,   1, 0, 64'h0,                   4'b0000, 0);
    add(0, 1, 16'h4444, 1, 1,   1, 1, 64'h4444_3333_2222_1111, 4'b1111, 1);
    add(0, 1, 16'hAAAA, 0, 1,   1, 0, 64'h4444_3333_2222_1111, 4'b1111, 1);
    add(0, 1, 16'hBBBB, 1, 1,   1, 1, 64'h0000_0000_BBBB_AAAA, 4'b0011, 1);
    add(0, 1, 16'hCCCC, 1, 1,   1, 1, 64'h0000_0000_0000_CCCC, 4'b0001, 1);
    add(0, 1, 16'hDDDD, 1, 1,   1, 1, 64'h0000_0000_0000_DDDD, 4'b0001, 1);
    add(0, 0, 16'h0000, 0, 1,   1, 0, 64'h0000_0000_0000_DDDD, 4'b0001, 1);
    add(0, 1, 16'h1111, 0, 1,   1, 0, 64'h0000_0000_0000_DDDD, 4'b0001, 1);
    add(0, 1, 16'h2222, 0, 1,   1, 0, 64'h0000_0000_0000_DDDD, 4'b0001, 1);
    add(1, 0, 16'h0000, 0, 1,   1, 0, 64'h0,                   4'b0000, 0);
    add(0, 1, 16'h3333, 0, 1,   1, 0, 64'h0,                   4'b0000, 0);
    add(0, 1, 16'h4444, 1, 1,   1, 1, 64'h0000_0000_4444_3333, 4'b0011, 1);
    add(0, 1, 16'h5555, 0, 0,   0, 1, 64'h0000_0000_4444_3333, 4'b0011, 1);
    add(0, 1, 16'h5555, 0, 0,   0, 1, 64'h0000_0000_4444_3333, 4'b0011, 1);
    add(0, 1, 16'h5555, 0, 1,   1, 0, 64'h0000_0000_4444_3333, 4'b0011, 1);
    add(0, 1, 16'h6666, 0, 1,   1, 0, 64'h0000_0000_4444_3333, 4'b0011, 1);
    add(0, 1, 16'h7777, 0, 1,   1, 0, 64'h0000_0000_4444_3333, 4'b0011, 1);
    add(0, 1, 16'h8888, 0, 1,   1, 1, 64'h8888_7777_6666_5555, 4'b1111, 0);
    add(0, 0, 16'h0000, 0, 1,   1, 0, 64'h8888_7777_6666_5555, 4'b1111, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].mr, sr);
      check($sformatf("vec%0d ready", i), OW'(sr),      OW'(tbl[i].sr));
      check($sformatf("vec%0d valid", i), OW'(m_valid), OW'(tbl[i].ov));
      check($sformatf("vec%0d data", i),  m_data,       tbl[i].od);
      check($sformatf("vec%0d keep", i),  OW'(m_keep),  OW'(tbl[i].ok));
      check($sformatf("vec%0d last", i),  OW'(m_last),  OW'(tbl[i].ol));
    end

    // Continuous streaming: a word right after every 4th beat, no bubbles.
    for (int i = 1; i <= 16; i++) begin
      apply(0, 1, IW'(i), (i % 4 == 0), 1, sr);
      check($sformatf("stream%0d ready", i), OW'(sr), OW'(1));
      check($sformatf("stream%0d valid", i), OW'(m_valid), OW'(i % 4 == 0));
      if (i % 4 == 0) begin
        logic [OW-1:0] w;
        w = {IW'(i), IW'(i - 1), IW'(i - 2), IW'(i - 3)};
        check($sformatf("stream%0d data", i), m_data, w);
        check($sformatf("stream%0d keep", i), OW'(m_keep), OW'(4'b1111));
      end
    end
    apply(0, 0, '0, 0, 1, sr);
    check("stream idle valid", OW'(m_valid), OW'(0));

    // Randomized traffic against the packing model.
    apply(1, 0, '0, 0, 1, sr);
    part.delete();
    e_valid = 1'b0; e_data = '0; e_keep = '0; e_last = 1'b0;
    refills = 0;
    for (int c = 0; c < 3000; c++) begin
      logic          v, l, mr;
      logic [IW-1:0] d;
      v  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 4) == 0);
      mr = ($urandom_range(0, 2) != 0);
      d  = IW'($urandom);
      exp_sr = !e_valid || mr;
      acc    = v && exp_sr;
      apply(0, v, d, l, mr, sr);
      check($sformatf("rnd%0d ready", c), OW'(sr), OW'(exp_sr));
      if (acc) part.push_back(d);
      if (acc && (part.size() == R || l)) begin
        if (e_valid && mr) refills++;
        e_data = '0;
        for (int k = 0; k < part.size(); k++)
          e_data = e_data | (OW'(part[k]) << (IW * k));
        e_keep  = R'((1 << part.size()) - 1);
        e_last  = l;
        e_valid = 1'b1;
        part.delete();
      end else if (e_valid && mr) begin
        e_valid = 1'b0;
      end
      check($sformatf("rnd%0d valid", c), OW'(m_valid), OW'(e_valid));
      check($sformatf("rnd%0d data", c),  m_data,       e_data);
      check($sformatf("rnd%0d keep", c),  OW'(m_keep),  OW'(e_keep));
      check($sformatf("rnd%0d last", c),  OW'(m_last),  OW'(e_last));
    end
    $display("random phase: %0d drain-and-refill cycles", refills);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
